// File: rtl/dft_stream_sequencer.sv
// dft_stream_sequencer
// Framing and flow-control wrapper around a streaming DFT core.
// Input side: beats are buffered in a FIFO. Once a whole frame is buffered and
// the core's minimum inter-frame gap has elapsed, the block pulses core_next and
// then drives FRAME_CYCLES contiguous beats onto core_x.
// Output side: a core_next_out pulse becomes a framed m_valid/m_last stream.
// Optional feature macro: DFT_SEQ_STATUS_EN enables the frames_in/frames_out
// counters and the sticky err_overrun flag; without it those ports read 0.
module dft_stream_sequencer #(
    parameter int WIDTH        = 64,
    parameter int LANES        = 16,
    parameter int FRAME_CYCLES = 64,
    parameter int GAP          = 272,
    parameter int FIFO_FRAMES  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [WIDTH*LANES-1:0]   s_data,
    output logic                     core_next,
    output logic [WIDTH*LANES-1:0]   core_x,
    input  logic                     core_next_out,
    input  logic [WIDTH*LANES-1:0]   core_y,
    output logic                     m_valid,
    output logic                     m_last,
    output logic [WIDTH*LANES-1:0]   m_data,
    output logic [15:0]              frames_in,
    output logic [15:0]              frames_out,
    output logic                     err_overrun
);
    localparam int BW     = WIDTH * LANES;
    localparam int DEPTH  = FIFO_FRAMES * FRAME_CYCLES;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int OCC_W  = $clog2(DEPTH + 1);
    localparam int BEAT_W = $clog2(FRAME_CYCLES);
    localparam int GCNT_W = $clog2(GAP + 1);

    localparam logic [OCC_W-1:0]  DEPTH_C   = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0]  FRAME_C   = OCC_W'(FRAME_CYCLES);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_CYCLES - 1);
    localparam logic [GCNT_W-1:0] GAP_C     = GCNT_W'(GAP);
    localparam logic [GCNT_W-1:0] GAP_M1    = GCNT_W'(GAP - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, STREAM = 2'd2} in_state_t;
    typedef enum logic       {OIDLE = 1'b0, OACT = 1'b1} out_state_t;

    logic [BW-1:0]     fifo_mem [DEPTH];
    in_state_t         in_state_q, in_state_d;
    out_state_t        out_state_q, out_state_d;
    logic              core_next_q, core_next_d;
    logic [BW-1:0]     core_x_q, core_x_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [GCNT_W-1:0] gcnt_q, gcnt_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              rdy_en_q, rdy_en_d;
    logic [BEAT_W-1:0] obeat_q, obeat_d;
    logic              m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic [BW-1:0]     m_data_q, m_data_d;
    logic              wr_s, rd_s, in_done_s, out_done_s;

    // Ready only once out of reset, and dropped as soon as the FIFO is full.
    assign s_ready    = rdy_en_q && (occ_q != DEPTH_C);
    assign wr_s       = s_valid && s_ready;
    // Beat 0 is fetched in ARM so core_x carries it on the first STREAM cycle.
    assign rd_s       = (in_state_q == ARM) || ((in_state_q == STREAM) && (beat_q != LAST_BEAT));
    assign in_done_s  = (in_state_q == STREAM) && (beat_q == LAST_BEAT);
    assign out_done_s = (out_state_q == OACT) && (obeat_q == LAST_BEAT);
    assign rdy_en_d   = 1'b1;

    // Input sequencer, gap counter and FIFO pointer/occupancy next state.
    always_comb begin
        in_state_d  = in_state_q;
        core_next_d = 1'b0;
        beat_d      = beat_q;
        if (gcnt_q != GAP_C) gcnt_d = gcnt_q + GCNT_W'(1);
        else                 gcnt_d = gcnt_q;
        case (in_state_q)
            IDLE: begin
                if ((occ_q >= FRAME_C) && (gcnt_q >= GAP_M1)) begin
                    in_state_d  = ARM;
                    core_next_d = 1'b1;
                    gcnt_d      = '0;
                end else begin
                    in_state_d  = IDLE;
                end
            end
            ARM: begin
                in_state_d = STREAM;
                beat_d     = '0;
            end
            STREAM: begin
                if (in_done_s) in_state_d = IDLE;
                else           beat_d     = beat_q + BEAT_W'(1);
            end
            default: in_state_d = IDLE;
        endcase
        if (rd_s) begin
            core_x_d = fifo_mem[rptr_q];
            rptr_d   = (rptr_q == PTR_LAST) ? '0 : rptr_q + PTR_W'(1);
        end else begin
            core_x_d = core_x_q;
            rptr_d   = rptr_q;
        end
        if (wr_s) wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + PTR_W'(1);
        else      wptr_d = wptr_q;
        case ({wr_s, rd_s})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Output framer: one core_next_out pulse yields FRAME_CYCLES registered beats.
    always_comb begin
        out_state_d = out_state_q;
        obeat_d     = obeat_q;
        m_valid_d   = 1'b0;
        m_last_d    = 1'b0;
        m_data_d    = m_data_q;
        case (out_state_q)
            OIDLE: begin
                if (core_next_out) begin
                    out_state_d = OACT;
                    obeat_d     = '0;
                    m_valid_d   = 1'b1;
                    m_last_d    = (LAST_BEAT == '0);
                    m_data_d    = core_y;
                end else begin
                    out_state_d = OIDLE;
                end
            end
            OACT: begin
                if (out_done_s) begin
                    out_state_d = OIDLE;
                end else begin
                    obeat_d   = obeat_q + BEAT_W'(1);
                    m_valid_d = 1'b1;
                    m_last_d  = ((obeat_q + BEAT_W'(1)) == LAST_BEAT);
                    m_data_d  = core_y;
                end
            end
            default: out_state_d = OIDLE;
        endcase
    end

    // FIFO storage; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (wr_s) fifo_mem[wptr_q] <= s_data;
    end

    // State and registered outputs for both sequencers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_state_q  <= IDLE;
            core_next_q <= 1'b0;
            core_x_q    <= '0;
            beat_q      <= '0;
            gcnt_q      <= GAP_C;
            wptr_q      <= '0;
            rptr_q      <= '0;
            occ_q       <= '0;
            rdy_en_q    <= 1'b0;
            out_state_q <= OIDLE;
            obeat_q     <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_data_q    <= '0;
        end else begin
            in_state_q  <= in_state_d;
            core_next_q <= core_next_d;
            core_x_q    <= core_x_d;
            beat_q      <= beat_d;
            gcnt_q      <= gcnt_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            occ_q       <= occ_d;
            rdy_en_q    <= rdy_en_d;
            out_state_q <= out_state_d;
            obeat_q     <= obeat_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            m_data_q    <= m_data_d;
        end
    end

    assign core_next = core_next_q;
    assign core_x    = core_x_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign m_data    = m_data_q;

`ifdef DFT_SEQ_STATUS_EN
    logic [15:0] frames_in_q, frames_in_d, frames_out_q, frames_out_d;
    logic        err_q, err_d, overrun_s;

    // A new output frame request while one is running is flagged, never restarted.
    assign overrun_s = (out_state_q == OACT) && core_next_out;

    // Wrapping frame counters and the sticky overrun flag.
    always_comb begin
        if (in_done_s)  frames_in_d  = frames_in_q + 16'd1;
        else            frames_in_d  = frames_in_q;
        if (out_done_s) frames_out_d = frames_out_q + 16'd1;
        else            frames_out_d = frames_out_q;
        if (overrun_s)  err_d = 1'b1;
        else            err_d = err_q;
    end

    // Status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frames_in_q  <= 16'd0;
            frames_out_q <= 16'd0;
            err_q        <= 1'b0;
        end else begin
            frames_in_q  <= frames_in_d;
            frames_out_q <= frames_out_d;
            err_q        <= err_d;
        end
    end

    assign frames_in   = frames_in_q;
    assign frames_out  = frames_out_q;
    assign err_overrun = err_q;
`else
    assign frames_in   = 16'd0;
    assign frames_out  = 16'd0;
    assign err_overrun = 1'b0;
`endif
endmodule
